// File: rtl/syn_lb_pkg.sv
// Shared definitions for the cortex Local Bus router: FSM encoding, error/IRQ constants
// and the block codes of the blocks hanging off the router.
package syn_lb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lb_state_e;

  localparam logic [31:0] LB_ERR_DATA     = 32'hDEAD_DEAD;
  localparam logic [3:0]  LB_IRQ_CLR_CODE = 4'hF;

  localparam logic [3:0] BLK_ACORTEX      = 4'd0;
  localparam logic [3:0] BLK_VCORTEX      = 4'd1;
  localparam logic [3:0] BLK_FGYRUS_LCHNL = 4'd2;
  localparam logic [3:0] BLK_FGYRUS_RCHNL = 4'd3;

  localparam int ERR_CNT_W = 8;

endpackage

// File: rtl/syn_lb_rsp_mux.sv
// Selects the valid strobes and read data of the block currently owning the outstanding
// transaction. Purely combinational; sel_i is the registered block code.
module syn_lb_rsp_mux #(
  parameter int P_NUM_BLKS  = 4,
  parameter int P_LB_DATA_W = 32,
  parameter int P_CODE_W    = 4
) (
  input  logic [P_CODE_W-1:0]               sel_i,
  input  logic [P_NUM_BLKS-1:0]             rd_valid_i,
  input  logic [P_NUM_BLKS-1:0]             wr_valid_i,
  input  logic [P_NUM_BLKS*P_LB_DATA_W-1:0] rd_data_i,
  output logic                              rd_valid_o,
  output logic                              wr_valid_o,
  output logic [P_LB_DATA_W-1:0]            rd_data_o
);

  always_comb begin
    rd_valid_o = 1'b0;
    wr_valid_o = 1'b0;
    rd_data_o  = '0;
    for (int i = 0; i < P_NUM_BLKS; i++) begin
      if (sel_i == P_CODE_W'(i)) begin
        rd_valid_o = rd_valid_i[i];
        wr_valid_o = wr_valid_i[i];
        rd_data_o  = rd_data_i[i*P_LB_DATA_W +: P_LB_DATA_W];
      end
    end
  end

endmodule

// File: rtl/syn_lb_router.sv
// Local Bus router: decodes the block code, forwards one transaction at a time, times out
// silent blocks and keeps a saturating count of every error, drop and stray valid.
module syn_lb_router
  import syn_lb_pkg::*;
#(
  parameter int                     P_NUM_BLKS     = 4,
  parameter int                     P_LB_ADDR_W    = 16,
  parameter int                     P_LB_DATA_W    = 32,
  parameter int                     P_BLK_ADDR_W   = 12,
  parameter int                     P_CODE_W       = 4,
  parameter logic [P_CODE_W-1:0]    P_IRQ_CLR_CODE = LB_IRQ_CLR_CODE,
  parameter int                     P_TIMEOUT_CYC  = 1023,
  parameter logic [P_LB_DATA_W-1:0] P_ERR_DATA     = LB_ERR_DATA
) (
  input  logic                              clk_ir,
  input  logic                              rst_il,
  input  logic                              lb_rd_en_ih,
  input  logic                              lb_wr_en_ih,
  input  logic [P_LB_ADDR_W-1:0]            lb_addr_id,
  input  logic [P_LB_DATA_W-1:0]            lb_wr_data_id,
  output logic                              lb_rd_valid_od,
  output logic [P_LB_DATA_W-1:0]            lb_rd_data_od,
  output logic                              lb_wr_valid_od,
  output logic                              lb_err_oh,
  output logic                              lb_busy_oh,
  output logic                              irq_rst_oh,
  output logic [P_NUM_BLKS-1:0]             blk_wr_en_od,
  output logic [P_NUM_BLKS-1:0]             blk_rd_en_od,
  output logic [P_BLK_ADDR_W-1:0]           blk_addr_od,
  output logic [P_LB_DATA_W-1:0]            blk_wr_data_od,
  input  logic [P_NUM_BLKS-1:0]             blk_wr_valid_id,
  input  logic [P_NUM_BLKS-1:0]             blk_rd_valid_id,
  input  logic [P_NUM_BLKS*P_LB_DATA_W-1:0] blk_rd_data_id,
  output logic [ERR_CNT_W-1:0]              err_cnt_od
);

  localparam int CNT_W = $clog2(P_TIMEOUT_CYC + 1);
  localparam logic [P_CODE_W:0] NUM_BLKS_C = (P_CODE_W + 1)'(P_NUM_BLKS);

  lb_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          tmo_q, tmo_d;
  logic [P_CODE_W-1:0]       sel_q, sel_d;
  logic                      dir_wr_q, dir_wr_d;
  logic                      rd_valid_q, rd_valid_d;
  logic                      wr_valid_q, wr_valid_d;
  logic                      err_q, err_d;
  logic                      irq_q, irq_d;
  logic [P_NUM_BLKS-1:0]     blk_wr_en_q, blk_wr_en_d;
  logic [P_NUM_BLKS-1:0]     blk_rd_en_q, blk_rd_en_d;
  logic [P_BLK_ADDR_W-1:0]   blk_addr_q, blk_addr_d;
  logic [P_LB_DATA_W-1:0]    blk_wdata_q, blk_wdata_d;
  logic [P_LB_DATA_W-1:0]    rd_data_q, rd_data_d;
  logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;

  logic                      req;
  logic [P_CODE_W-1:0]       req_code;
  logic                      req_mapped;
  logic [P_NUM_BLKS-1:0]     code_oh, sel_oh;
  logic [P_NUM_BLKS-1:0]     rd_expect, wr_expect;
  logic                      stray;
  logic                      req_err, tmo_err;
  logic                      hit_rd, hit_wr, hit;
  logic [P_LB_DATA_W-1:0]    hit_data;
  logic [ERR_CNT_W:0]        cnt_sum;

  assign req        = lb_rd_en_ih | lb_wr_en_ih;
  assign req_code   = lb_addr_id[P_LB_ADDR_W-1 -: P_CODE_W];
  assign req_mapped = ({1'b0, req_code} < NUM_BLKS_C);

  generate
    for (genvar gi = 0; gi < P_NUM_BLKS; gi++) begin : g_onehot
      assign code_oh[gi] = (req_code == P_CODE_W'(gi));
      assign sel_oh[gi]  = (sel_q == P_CODE_W'(gi));
    end
  endgenerate

  // Only the selected block's valid in the pending direction is legal; anything else is stray.
  assign rd_expect = (state_q == ST_WAIT && !dir_wr_q) ? sel_oh : '0;
  assign wr_expect = (state_q == ST_WAIT &&  dir_wr_q) ? sel_oh : '0;
  assign stray     = (|(blk_rd_valid_id & ~rd_expect)) | (|(blk_wr_valid_id & ~wr_expect));

  syn_lb_rsp_mux #(
    .P_NUM_BLKS  (P_NUM_BLKS),
    .P_LB_DATA_W (P_LB_DATA_W),
    .P_CODE_W    (P_CODE_W)
  ) u_rsp_mux (
    .sel_i      (sel_q),
    .rd_valid_i (blk_rd_valid_id),
    .wr_valid_i (blk_wr_valid_id),
    .rd_data_i  (blk_rd_data_id),
    .rd_valid_o (hit_rd),
    .wr_valid_o (hit_wr),
    .rd_data_o  (hit_data)
  );

  assign hit = dir_wr_q ? hit_wr : hit_rd;

  always_comb begin
    state_d     = state_q;
    tmo_d       = tmo_q;
    sel_d       = sel_q;
    dir_wr_d    = dir_wr_q;
    blk_addr_d  = blk_addr_q;
    blk_wdata_d = blk_wdata_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    wr_valid_d  = 1'b0;
    err_d       = 1'b0;
    irq_d       = 1'b0;
    blk_wr_en_d = '0;
    blk_rd_en_d = '0;
    req_err     = 1'b0;
    tmo_err     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          sel_d       = req_code;
          dir_wr_d    = lb_wr_en_ih;
          blk_addr_d  = lb_addr_id[P_BLK_ADDR_W-1:0];
          blk_wdata_d = lb_wr_data_id;
          if (lb_rd_en_ih && lb_wr_en_ih) begin
            wr_valid_d = 1'b1;
            err_d      = 1'b1;
            req_err    = 1'b1;
          end else if (req_mapped) begin
            blk_wr_en_d = lb_wr_en_ih ? code_oh : '0;
            blk_rd_en_d = lb_rd_en_ih ? code_oh : '0;
            tmo_d       = '0;
            state_d     = ST_WAIT;
          end else if (req_code == P_IRQ_CLR_CODE) begin
            irq_d      = 1'b1;
            wr_valid_d = lb_wr_en_ih;
            rd_valid_d = lb_rd_en_ih;
            if (lb_rd_en_ih) rd_data_d = '0;
          end else begin
            wr_valid_d = lb_wr_en_ih;
            rd_valid_d = lb_rd_en_ih;
            err_d      = 1'b1;
            req_err    = 1'b1;
            if (lb_rd_en_ih) rd_data_d = P_ERR_DATA;
          end
        end
      end
      ST_WAIT: begin
        req_err = req;
        // A hit in the timeout cycle still wins over the error response.
        if (hit) begin
          wr_valid_d = dir_wr_q;
          rd_valid_d = !dir_wr_q;
          if (!dir_wr_q) rd_data_d = hit_data;
          state_d = ST_IDLE;
        end else if (tmo_q == CNT_W'(P_TIMEOUT_CYC)) begin
          wr_valid_d = dir_wr_q;
          rd_valid_d = !dir_wr_q;
          err_d      = 1'b1;
          tmo_err    = 1'b1;
          if (!dir_wr_q) rd_data_d = P_ERR_DATA;
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_sum   = {1'b0, err_cnt_q} + (ERR_CNT_W + 1)'(req_err) + (ERR_CNT_W + 1)'(tmo_err)
              + (ERR_CNT_W + 1)'(stray);
    err_cnt_d = cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      state_q     <= ST_IDLE;
      tmo_q       <= '0;
      sel_q       <= '0;
      dir_wr_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      wr_valid_q  <= 1'b0;
      err_q       <= 1'b0;
      irq_q       <= 1'b0;
      blk_wr_en_q <= '0;
      blk_rd_en_q <= '0;
      blk_addr_q  <= '0;
      blk_wdata_q <= '0;
      rd_data_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      sel_q       <= sel_d;
      dir_wr_q    <= dir_wr_d;
      rd_valid_q  <= rd_valid_d;
      wr_valid_q  <= wr_valid_d;
      err_q       <= err_d;
      irq_q       <= irq_d;
      blk_wr_en_q <= blk_wr_en_d;
      blk_rd_en_q <= blk_rd_en_d;
      blk_addr_q  <= blk_addr_d;
      blk_wdata_q <= blk_wdata_d;
      rd_data_q   <= rd_data_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign lb_rd_valid_od = rd_valid_q;
  assign lb_rd_data_od  = rd_data_q;
  assign lb_wr_valid_od = wr_valid_q;
  assign lb_err_oh      = err_q;
  assign lb_busy_oh     = (state_q == ST_WAIT);
  assign irq_rst_oh     = irq_q;
  assign blk_wr_en_od   = blk_wr_en_q;
  assign blk_rd_en_od   = blk_rd_en_q;
  assign blk_addr_od    = blk_addr_q;
  assign blk_wr_data_od = blk_wdata_q;
  assign err_cnt_od     = err_cnt_q;

endmodule
